// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter.
// Frames are start bit, DATA_BITS payload bits sent LSB first, an optional
// parity bit, and STOP_BITS stop bits. Every bit lasts CLK_FREQ/BAUD clocks.
// All outputs are registered. Reset is synchronous and active high.
module uart_tx_param #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic [DATA_BITS-1:0] data,
    output logic                 ready,
    output logic                 busy,
    output logic                 dout
);

    localparam int BAUD_DIV = CLK_FREQ / BAUD;
    localparam int CNT_W    = ($clog2(BAUD_DIV) < 1) ? 1 : $clog2(BAUD_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic             ODD_PAR   = (PARITY == 1);

    // Reject unusable configurations at elaboration time.
    generate
        if (BAUD_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
            $error("uart_tx_param: illegal parameter set");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     baud_cnt;
    logic [3:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;

    // Frame sequencer: accepts a word in IDLE and walks it out bit by bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            dout     <= 1'b1;
            ready    <= 1'b1;
            busy     <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            par_bit  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid && ready) begin
                        shreg    <= data;
                        par_bit  <= (^data) ^ ODD_PAR;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        dout     <= 1'b0;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end

                START: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        dout     <= shreg[0];
                        shreg    <= shreg >> 1;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            if (PARITY != 0) begin
                                dout  <= par_bit;
                                state <= PAR;
                            end else begin
                                dout  <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                            dout    <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                PAR: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        dout     <= 1'b1;
                        state    <= STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (baud_cnt == CNT_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            bit_idx <= '0;
                            dout    <= 1'b1;
                            ready   <= 1'b1;
                            busy    <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            bit_idx <= bit_idx + 4'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                    dout  <= 1'b1;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
